// File: rtl/mix_char_convert_if.sv
// mix_char_convert_if: start/stop pulse handshake and data bus of the CHAR converter
interface mix_char_convert_if;
  logic        start;
  logic [29:0] in;
  logic        stop;
  logic [59:0] out;
  modport master (output start, in, input stop, out);
  modport slave (input start, in, output stop, out);
endinterface

// File: rtl/mix_char_convert.sv
// mix_char_convert: MIX CHAR, 30-bit magnitude to ten character codes via 30-step double dabble.
// Optional CHAR_BLANK_LEADING_EN encodes leading zero digits as blank (code 0).
module mix_char_convert #(
  parameter int ZERO_CODE = 30
) (
  input logic             clk,
  input logic             reset,
  mix_char_convert_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CONVERT = 1'b1;
  logic [0:0]  state_q;
  logic [4:0]  cnt_q;
  logic [29:0] sh_q;
  logic [39:0] bcd_q, adj_d;
  logic [59:0] out_q, code_d;
  logic        stop_q;
  logic        lead;
  always_comb begin
    adj_d = bcd_q;
    for (int i = 0; i < 10; i++)
      adj_d[i*4+:4] = bcd_q[i*4+:4] >= 4'd5 ? bcd_q[i*4+:4] + 4'd3 : bcd_q[i*4+:4];
  end
  // lead stays set while scanning zero digits from the MSB; the units digit is never blanked
  always_comb begin
    code_d = '0;
    lead = 1'b1;
    for (int i = 9; i >= 0; i--) begin
`ifdef CHAR_BLANK_LEADING_EN
      lead = lead && bcd_q[i*4+:4] == 4'd0 && i != 0;
`else
      lead = 1'b0;
`endif
      code_d[i*6+:6] = lead ? 6'd0 : 6'(ZERO_CODE) + {2'b00, bcd_q[i*4+:4]};
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sh_q <= '0;
      bcd_q <= '0;
      out_q <= '0;
      stop_q <= 1'b0;
    end else begin
      stop_q <= 1'b0;
      if (state_q == IDLE) begin
        if (bus.start) begin
          sh_q <= bus.in;
          bcd_q <= '0;
          cnt_q <= 5'd30;
          state_q <= CONVERT;
        end
      end else if (cnt_q != 5'd0) begin
        bcd_q <= {adj_d[38:0], sh_q[29]};
        sh_q <= {sh_q[28:0], 1'b0};
        cnt_q <= cnt_q - 5'd1;
      end else begin
        out_q <= code_d;
        stop_q <= 1'b1;
        state_q <= IDLE;
      end
    end
  assign bus.stop = stop_q;
  assign bus.out = out_q;
endmodule

// File: tb/tb_mix_char_convert.sv
// tb_mix_char_convert: scoreboard bench for mix_char_convert (honours CHAR_BLANK_LEADING_EN)
module tb_mix_char_convert;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   stop_cnt = 0;
  logic [59:0] exp_q[$];
  int          cyc_q[$];
  mix_char_convert_if bus ();
  mix_char_convert #(.ZERO_CODE(30)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask
  function automatic logic [59:0] model(input logic [29:0] v);
    logic [59:0] r;
    int unsigned x, p, d;
    bit lead;
    r = '0;
    x = v;
    lead = 1'b1;
    for (int i = 9; i >= 0; i--) begin
      p = 1;
      for (int k = 0; k < i; k++) p *= 10;
      d = (x / p) % 10;
`ifdef CHAR_BLANK_LEADING_EN
      lead = lead && d == 0 && i != 0;
`else
      lead = 1'b0;
`endif
      r[i*6+:6] = lead ? 6'd0 : 6'(30 + d);
    end
    return r;
  endfunction
  always @(negedge clk)
    if (!reset && bus.stop) begin
      stop_cnt++;
      if (exp_q.size() == 0) chk("spurious_stop", 1, 0);
      else begin
        chk("out", bus.out, exp_q.pop_front());
        chk("latency", cyc, cyc_q.pop_front());
      end
    end
  task automatic go(input logic [29:0] v, input bit push);
    bus.start = 1'b1;
    bus.in = v;
    if (push) begin
      exp_q.push_back(model(v));
      cyc_q.push_back(cyc + 32);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic wait_done();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    chk("timeout", exp_q.size(), 0);
  endtask
  initial begin
    int sc;
    logic [59:0] prev;
    bus.start = 1'b0;
    bus.in = '0;
    repeat (3) @(negedge clk);
    chk("rst_stop", bus.stop, 0);
    chk("rst_out", bus.out, 0);
    reset = 1'b0;
    @(negedge clk);
    go(30'd0, 1);
    wait_done();
    go(30'd12977, 1);
    wait_done();
`ifndef CHAR_BLANK_LEADING_EN
    chk("plan_12977", bus.out, {6'd30,6'd30,6'd30,6'd30,6'd30,6'd31,6'd32,6'd39,6'd37,6'd37});
`endif
    go(30'h3fffffff, 1);
    wait_done();
`ifndef CHAR_BLANK_LEADING_EN
    chk("plan_max", bus.out, {6'd31,6'd30,6'd37,6'd33,6'd37,6'd34,6'd31,6'd38,6'd32,6'd33});
`endif
    for (int i = 0; i < 6; i++) begin
      go(30'($urandom_range(0, 30'h3fffffff)), 1);
      wait_done();
    end
    sc = stop_cnt;
    go(30'd5, 1);
    repeat (8) @(negedge clk);
    go(30'd9, 0);
    wait_done();
    repeat (35) @(negedge clk);
    chk("ignored_start", stop_cnt - sc, 1);
    chk("last_digit5", bus.out[5:0], 6'd35);
    prev = bus.out;
    go(30'd9, 1);
    repeat (15) @(negedge clk);
    chk("out_hold", bus.out, prev);
    wait_done();
    chk("last_digit9", bus.out[5:0], 6'd39);
    go(30'd123456, 1);
    for (int i = 0; i < 40 && !bus.stop; i++) @(negedge clk);
    go(30'd987654321, 1);
    wait_done();
    sc = stop_cnt;
    go(30'd77, 0);
    repeat (13) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.in = 30'd3;
    @(negedge clk);
    bus.start = 1'b0;
    reset = 1'b0;
    chk("abort_out", bus.out, 0);
    chk("abort_stop", bus.stop, 0);
    repeat (40) @(negedge clk);
    chk("abort_nostop", stop_cnt - sc, 0);
    go(30'd42, 1);
    wait_done();
`ifdef CHAR_BLANK_LEADING_EN
    chk("blank_42", bus.out, {6'd0,6'd0,6'd0,6'd0,6'd0,6'd0,6'd0,6'd0,6'd34,6'd32});
`else
    chk("plain_42", bus.out, {6'd30,6'd30,6'd30,6'd30,6'd30,6'd30,6'd30,6'd30,6'd34,6'd32});
`endif
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
